// File: rtl/sched_obstaculos_pkg.sv
// Shared types and constants for the obstacle scheduler of the lane game.
package pkg_obstaculos;

  localparam logic [4:0]  TIPO_BONO  = 5'd16;
  localparam int unsigned NUM_TIPOS  = 17;
  localparam int unsigned LANES      = 7;

  // Fibonacci taps 16,14,13,11 -> state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } estado_t;

  // 16-bit add that sticks at all ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/sched_obstaculos_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick obstacle pattern indices.
module lfsr16
  import pkg_obstaculos::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] estado
);

  logic [15:0] estado_q;

  // Shift every cycle; feedback is the parity of the tapped bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= SEED;
    end else begin
      estado_q <= {estado_q[14:0], ^(estado_q & LFSR_TAPS)};
    end
  end

  assign estado = estado_q;

endmodule

// File: rtl/sched_obstaculos.sv
// Obstacle scheduler: picks ROM rows, scrolls the field, detects hits and keeps score.
// Optional macro SCHED_SPEEDUP_EN shortens the spawn gap as the score grows.
module sched_obstaculos
  import pkg_obstaculos::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned GAP          = 3,
  parameter int unsigned BONUS_PERIOD = 8,
  parameter int unsigned BONUS_PTS    = 5,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   tick,
  input  logic                   pausa,
  input  logic [2:0]             jugador_pos,
  input  logic [LANES-1:0]       obstaculo,
  output logic [4:0]             tipo_obs,
  output logic [LANES*DEPTH-1:0] campo,
  output logic                   choque,
  output logic                   bono,
  output logic [15:0]            puntos,
  output logic                   jugando
);

  localparam logic [7:0] GAP_W   = 8'(GAP);
  localparam logic [7:0] SP_LAST = 8'(BONUS_PERIOD - 1);

  estado_t                  estado_q, estado_d;
  logic [LANES*DEPTH-1:0]   campo_q, campo_d;
  logic [DEPTH-2:0]         flags_q, flags_d;   // bonus flag per row 0..DEPTH-2
  logic [7:0]               gap_q, gap_d;
  logic [7:0]               spawn_cnt_q, spawn_cnt_d;
  logic                     pend_q, pend_d;     // index selection due after a spawn
  logic [4:0]               tipo_q, tipo_d;
  logic                     choque_q, choque_d;
  logic                     bono_q, bono_d;
  logic [15:0]              puntos_q, puntos_d;

  logic [15:0]      lfsr;
  logic [7:0]       eff_gap;
  logic             arranque;
  logic             acc;
  logic             spawn;
  logic [LANES-1:0] fila;
  logic [2:0]       carril;
  logic             golpe;
  logic [15:0]      suma;
  logic [7:0]       cnt_next;
  logic             unused_lfsr;

  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .estado (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:4];

  // Row about to enter the player row and the lane it is checked against.
  assign fila   = campo_q[LANES*(DEPTH-2) +: LANES];
  assign carril = (jugador_pos == 3'd7) ? 3'd6 : jugador_pos;
  assign golpe  = fila[carril];

  // FSM, field scroll, spawn, next-index selection and scoring.
  always_comb begin
    estado_d    = estado_q;
    campo_d     = campo_q;
    flags_d     = flags_q;
    gap_d       = gap_q;
    spawn_cnt_d = spawn_cnt_q;
    pend_d      = pend_q;
    tipo_d      = tipo_q;
    choque_d    = 1'b0;
    bono_d      = 1'b0;
    puntos_d    = puntos_q;
    arranque    = 1'b0;
    acc         = 1'b0;
    spawn       = 1'b0;
    suma        = 16'd0;
    cnt_next    = (spawn_cnt_q == SP_LAST) ? 8'd0 : spawn_cnt_q + 8'd1;

    unique case (estado_q)
      IDLE, OVER: begin
        if (start) begin
          arranque    = 1'b1;
          estado_d    = RUN;
          campo_d     = '0;
          flags_d     = '0;
          puntos_d    = 16'd0;
          gap_d       = 8'd0;
          spawn_cnt_d = 8'd0;
          pend_d      = 1'b0;
        end
      end
      RUN: begin
        if (!pausa) begin
          if (pend_q) begin
            pend_d      = 1'b0;
            spawn_cnt_d = cnt_next;
            tipo_d      = (cnt_next == SP_LAST) ? TIPO_BONO : {1'b0, lfsr[3:0]};
          end
          if (tick) begin
            acc     = 1'b1;
            spawn   = (gap_q == eff_gap - 8'd1);
            campo_d = {campo_q[LANES*(DEPTH-1)-1:0], spawn ? obstaculo : {LANES{1'b0}}};
            flags_d = {flags_q[DEPTH-3:0], spawn && (tipo_q == TIPO_BONO)};
            gap_d   = spawn ? 8'd0 : gap_q + 8'd1;
            if (spawn) begin
              pend_d = 1'b1;
            end
            if (golpe && !flags_q[DEPTH-2]) begin
              choque_d = 1'b1;
              estado_d = OVER;
            end else if (golpe) begin
              bono_d = 1'b1;
              suma   = 16'(BONUS_PTS);
            end else if ((fila != '0) && !flags_q[DEPTH-2]) begin
              suma = 16'd1;
            end
            puntos_d = sat_add16(puntos_q, suma);
          end
        end
      end
      default: estado_d = IDLE;
    endcase
  end

`ifdef SCHED_SPEEDUP_EN
  logic [7:0] gap_tgt_q, gap_tgt_d;
  logic [7:0] eff_gap_q, eff_gap_d;

  // Target gap drops on each 16-point boundary; the live gap adopts it only at a spawn.
  always_comb begin
    gap_tgt_d = gap_tgt_q;
    eff_gap_d = eff_gap_q;
    if (arranque) begin
      gap_tgt_d = GAP_W;
      eff_gap_d = GAP_W;
    end else if (acc) begin
      if ((puntos_d[15:4] != puntos_q[15:4]) && (gap_tgt_q > 8'd1)) begin
        gap_tgt_d = gap_tgt_q - 8'd1;
      end
      if (spawn) begin
        eff_gap_d = gap_tgt_d;
      end
    end
  end

  // Speed-up registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_tgt_q <= GAP_W;
      eff_gap_q <= GAP_W;
    end else begin
      gap_tgt_q <= gap_tgt_d;
      eff_gap_q <= eff_gap_d;
    end
  end

  assign eff_gap = eff_gap_q;
`else
  assign eff_gap = GAP_W;
`endif

  // Game state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q    <= IDLE;
      campo_q     <= '0;
      flags_q     <= '0;
      gap_q       <= 8'd0;
      spawn_cnt_q <= 8'd0;
      pend_q      <= 1'b0;
      tipo_q      <= 5'd0;
      choque_q    <= 1'b0;
      bono_q      <= 1'b0;
      puntos_q    <= 16'd0;
    end else begin
      estado_q    <= estado_d;
      campo_q     <= campo_d;
      flags_q     <= flags_d;
      gap_q       <= gap_d;
      spawn_cnt_q <= spawn_cnt_d;
      pend_q      <= pend_d;
      tipo_q      <= tipo_d;
      choque_q    <= choque_d;
      bono_q      <= bono_d;
      puntos_q    <= puntos_d;
    end
  end

  assign tipo_obs = tipo_q;
  assign campo    = campo_q;
  assign choque   = choque_q;
  assign bono     = bono_q;
  assign puntos   = puntos_q;
  assign jugando  = (estado_q == RUN);

endmodule

// File: tb/tb_sched_obstaculos.sv
// Directed bench for sched_obstaculos: spawn cadence, collision, scoring, bonus, pause, reset.
module tb_sched_obstaculos;

  localparam int unsigned DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 start = 1'b0;
  logic                 tick = 1'b0;
  logic                 pausa = 1'b0;
  logic [2:0]           jugador_pos = 3'd4;
  logic [6:0]           pat = 7'h04;
  logic [6:0]           obstaculo;
  logic [4:0]           tipo_obs;
  logic [7*DEPTH-1:0]   campo;
  logic                 choque;
  logic                 bono;
  logic [15:0]          puntos;
  logic                 jugando;

  int                   n_cmp = 0;
  int                   n_bad = 0;
  logic [15:0]          m;          // reference LFSR
  logic [4:0]           exp_tipo;
  int                   sc;
  logic [55:0]          exp_campo;

  always #5 clk = ~clk;

  // Pattern ROM stand-in: bonus index gives a full row, everything else the current pattern.
  assign obstaculo = (tipo_obs == 5'd16) ? 7'h7F : pat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= 16'hACE1;
    else        m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  sched_obstaculos dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .tick        (tick),
    .pausa       (pausa),
    .jugador_pos (jugador_pos),
    .obstaculo   (obstaculo),
    .tipo_obs    (tipo_obs),
    .campo       (campo),
    .choque      (choque),
    .bono        (bono),
    .puntos      (puntos),
    .jugando     (jugando)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at the falling edge, return 1 time unit after the rising edge.
  task automatic step(input logic t, input logic s);
    @(negedge clk);
    tick  = t;
    start = s;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_campo", 64'(campo), 64'd0);
    check("rst_tipo", 64'(tipo_obs), 64'd0);
    check("rst_choque", 64'(choque), 64'd0);
    check("rst_bono", 64'(bono), 64'd0);
    check("rst_puntos", 64'(puntos), 64'd0);
    check("rst_jugando", 64'(jugando), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Game 1: spawn cadence, a pass (+1), then a collision in lane 2.
    step(1'b1, 1'b0);
    check("idle_tick_ign", 64'(campo), 64'd0);
    step(1'b0, 1'b1);
    check("g1_jugando", 64'(jugando), 64'd1);
    for (int k = 1; k <= 13; k++) begin
      step(1'b1, 1'b0);
      if (k <= 9) check($sformatf("g1_row0_t%0d", k), 64'(campo[6:0]), (k % 3 == 0) ? 64'(pat) : 64'd0);
      if (k == 10) begin
        check("g1_row7", 64'(campo[55:49]), 64'h04);
        check("g1_pts1", 64'(puntos), 64'd1);
        check("g1_nochoque", 64'(choque), 64'd0);
        jugador_pos = 3'd2;
      end
    end
    exp_campo = (56'h4 << 7) | (56'h4 << 28) | (56'h4 << 49);
    check("g1_choque", 64'(choque), 64'd1);
    check("g1_over", 64'(jugando), 64'd0);
    check("g1_campo", 64'(campo), 64'(exp_campo));
    step(1'b0, 1'b0);
    check("g1_choque_pulse", 64'(choque), 64'd0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("g1_frozen", 64'(campo), 64'(exp_campo));
    check("g1_pts_frozen", 64'(puntos), 64'd1);

    // Game 2: restart from OVER, scoring and the bonus row on the eighth spawn.
    pat = 7'h01;
    jugador_pos = 3'd4;
    step(1'b0, 1'b1);
    check("g2_jugando", 64'(jugando), 64'd1);
    check("g2_pts0", 64'(puntos), 64'd0);
    check("g2_campo0", 64'(campo), 64'd0);
    sc = 0;
    for (int k = 1; k <= 31; k++) begin
      step(1'b1, 1'b0);
      if (k >= 4 && (k % 3 == 1)) check($sformatf("g2_tipo_t%0d", k), 64'(tipo_obs), 64'(exp_tipo));
      if (k % 3 == 0) begin
        sc = (sc == 7) ? 0 : sc + 1;
        exp_tipo = (sc == 7) ? 5'd16 : {1'b0, m[3:0]};
      end
      if (k == 22) check("g2_tipo_bono", 64'(tipo_obs), 64'd16);
      if (k == 24) check("g2_row0_bono", 64'(campo[6:0]), 64'h7F);
      if (k == 28) check("g2_pts7", 64'(puntos), 64'd7);
    end
    check("g2_bono", 64'(bono), 64'd1);
    check("g2_bono_nochoque", 64'(choque), 64'd0);
    check("g2_pts12", 64'(puntos), 64'd12);
    step(1'b0, 1'b0);
    check("g2_bono_pulse", 64'(bono), 64'd0);

    // Pause with tick held high for 20 cycles.
    @(negedge clk);
    pausa = 1'b1;
    tick  = 1'b1;
    repeat (20) @(negedge clk);
    tick  = 1'b0;
    pausa = 1'b0;
    exp_campo = (56'h1 << 7) | (56'h1 << 28) | (56'h7F << 49);
    check("pausa_campo", 64'(campo), 64'(exp_campo));
    check("pausa_pts", 64'(puntos), 64'd12);
    check("pausa_tipo", 64'(tipo_obs), 64'(exp_tipo));
    step(1'b1, 1'b0);
    exp_campo = (56'h1 << 14) | (56'h1 << 35);
    check("resume_campo", 64'(campo), 64'(exp_campo));
    check("resume_pts", 64'(puntos), 64'd12);

    // Asynchronous reset between edges, then a fresh game.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_campo", 64'(campo), 64'd0);
    check("arst_pts", 64'(puntos), 64'd0);
    check("arst_jugando", 64'(jugando), 64'd0);
    check("arst_tipo", 64'(tipo_obs), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step(1'b0, 1'b1);
    check("g3_jugando", 64'(jugando), 64'd1);
    check("g3_pts0", 64'(puntos), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0);
      check($sformatf("g3_row0_t%0d", k), 64'(campo[6:0]), (k == 3) ? 64'(pat) : 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
